// File: rtl/test_ram_be_64.sv
// rtl/test_ram_be_64.sv - byte-enable 64-bit test memory with init sweep, OOB detection and access counters
module test_ram_be_64 #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter logic [63:0] INIT_VALUE  = 64'h0,
  parameter logic [63:0] OOB_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF,
  // Reset value of both access counters; a nonzero preset brings saturation within reach.
  parameter logic [31:0] COUNT_RESET = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] rdata_o,
  output logic        init_busy_o,
  output logic        oob_err_o,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("test_ram_be_64: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;

  logic [63:0]     mem_q [DEPTH];

  logic [63:0]     rdata_q, rdata_d;
  logic            oob_q, oob_d;
  logic [31:0]     rd_cnt_q, rd_cnt_d;
  logic [31:0]     wr_cnt_q, wr_cnt_d;

  logic [63:0]     off;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [63:0]     old_word;
  logic [63:0]     merged;
  logic            acc_en;

  // Address decode and byte-lane merge of the addressed word.
  always_comb begin
    off      = addr_i - BASE_ADDR;
    in_range = (addr_i >= BASE_ADDR) && (off < SPAN);
    idx      = off[3 +: AW];
    old_word = mem_q[idx];
    merged   = old_word;
    for (int n = 0; n < 8; n++) begin
      if (be_i[n]) begin
        merged[8*n +: 8] = wdata_i[8*n +: 8];
      end
    end
  end

  // Requests are only honoured once the sweep has finished.
  assign acc_en = req_i && (state_q == ST_RUN);

  // Next-state logic: sweep every word once, then serve accesses until reset.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // Read data, sticky error flag and saturating counters for an accepted access.
  always_comb begin
    rdata_d  = rdata_q;
    oob_d    = oob_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (acc_en) begin
      // Reads and writes both return the pre-write contents of the word.
      rdata_d = in_range ? old_word : OOB_PATTERN;
      if (!in_range) begin
        oob_d = 1'b1;
      end else if (we_i) begin
        wr_cnt_d = (wr_cnt_q == 32'hFFFF_FFFF) ? wr_cnt_q : wr_cnt_q + 32'd1;
      end else begin
        rd_cnt_d = (rd_cnt_q == 32'hFFFF_FFFF) ? rd_cnt_q : rd_cnt_q + 32'd1;
      end
    end
  end

  // Control and output registers; reset restarts the sweep from word 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      rdata_q  <= '0;
      oob_q    <= 1'b0;
      rd_cnt_q <= COUNT_RESET;
      wr_cnt_q <= COUNT_RESET;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      oob_q    <= oob_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Storage array: sweep writes during INIT, byte-merged writes during RUN.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q] <= INIT_VALUE;
    end else if (acc_en && we_i && in_range) begin
      mem_q[idx] <= merged;
    end
  end

  assign rdata_o     = rdata_q;
  assign init_busy_o = (state_q == ST_INIT);
  assign oob_err_o   = oob_q;
  assign rd_count_o  = rd_cnt_q;
  assign wr_count_o  = wr_cnt_q;

endmodule

// File: tb/tb_test_ram_be_64.sv
// tb/tb_test_ram_be_64.sv - scoreboard bench for test_ram_be_64
module tb_test_ram_be_64;

  localparam int          DEPTH = 16;
  localparam logic [63:0] INITV = 64'h0;
  localparam logic [63:0] OOB   = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [31:0] SPRE  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        s_req = 1'b0;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [7:0]  be = '0;
  logic [63:0] wdata = '0;

  logic [63:0] rdata, s_rdata;
  logic        busy, s_busy, oob, s_oob;
  logic [31:0] rd_cnt, wr_cnt, s_rd_cnt, s_wr_cnt;

  test_ram_be_64 #(.DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata), .init_busy_o(busy), .oob_err_o(oob),
    .rd_count_o(rd_cnt), .wr_count_o(wr_cnt)
  );

  test_ram_be_64 #(.DEPTH(DEPTH), .COUNT_RESET(SPRE)) u_sat (
    .clk_i(clk), .rst_i(rst), .req_i(s_req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .rdata_o(s_rdata), .init_busy_o(s_busy), .oob_err_o(s_oob),
    .rd_count_o(s_rd_cnt), .wr_count_o(s_wr_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] model_mem [DEPTH];
  logic [31:0] m_rd, m_wr;
  logic        m_oob;
  logic [63:0] exp_q [$];
  string       tag_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INITV;
    m_rd  = 0;
    m_wr  = 0;
    m_oob = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_rdata"}, rdata, 64'h0);
    check({p, "_oob"}, 64'(oob), 64'h0);
    check({p, "_rdcnt"}, 64'(rd_cnt), 64'h0);
    check({p, "_wrcnt"}, 64'(wr_cnt), 64'h0);
    check({p, "_busy"}, 64'(busy), 64'h1);
  endtask

  // One accepted access in RUN; expected rdata is pushed at drive time, popped after the edge.
  task automatic access(input bit w, input logic [63:0] a, input logic [7:0] b,
                        input logic [63:0] d, input string tag);
    logic [63:0] exp;
    bit          inr;
    int          ix;
    inr = (a < 64'(DEPTH * 8));
    ix  = int'(a[63:3] % DEPTH);
    exp = inr ? model_mem[ix] : OOB;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    if (!inr) m_oob = 1'b1;
    else if (w) begin
      m_wr++;
      for (int n = 0; n < 8; n++) if (b[n]) model_mem[ix][8*n +: 8] = d[8*n +: 8];
    end else m_rd++;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check(tag_q.pop_front(), rdata, exp_q.pop_front());
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n), 64'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("por");

    // Release reset with a read already pending; it must be dropped.
    rst = 1'b0;
    req = 1'b1; we = 1'b0; addr = 64'h40;
    @(negedge clk);
    req = 1'b0;
    begin
      int n;
      n = 1;
      while (busy && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("init_len", 64'(n), 64'd16);
    end
    check("busy_rd_cnt", 64'(rd_cnt), 64'd0);
    check("busy_rdata", rdata, 64'h0);

    access(1'b0, 64'h40, 8'h00, 64'h0, "rd40");
    check("rd40_cnt", 64'(rd_cnt), 64'(m_rd));

    access(1'b1, 64'h8, 8'hFF, 64'h0123_4567_89AB_CDEF, "wr8_full");
    access(1'b1, 64'h8, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, "wr8_low");
    access(1'b0, 64'h8, 8'hAA, 64'h5555, "rd8_merged");
    check("wr8_cnt", 64'(wr_cnt), 64'd2);

    access(1'b1, 64'h10, 8'hFF, 64'hABCD, "wr10_old");
    access(1'b0, 64'h10, 8'h00, 64'h0, "rd10_b2b");

    access(1'b0, 64'h10 + 64'(DEPTH * 8), 8'h00, 64'h0, "rd_oob");
    check("oob_set", 64'(oob), 64'h1);
    repeat (10) @(negedge clk);
    check("oob_sticky", 64'(oob), 64'h1);
    check("oob_hold_rdata", rdata, OOB);
    check("oob_rdcnt", 64'(rd_cnt), 64'(m_rd));
    check("oob_wrcnt", 64'(wr_cnt), 64'(m_wr));
    access(1'b0, 64'h10, 8'h00, 64'h0, "rd10_after_oob");
    access(1'b0, 64'h13, 8'h00, 64'h0, "rd13_misalign");

    access(1'b1, 64'h18, 8'h00, 64'hFFFF, "wr18_be0");
    access(1'b0, 64'h18, 8'h00, 64'h0, "rd18_be0");
    access(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'h1234, "wr_oob");
    check("wr_oob_cnt", 64'(wr_cnt), 64'(m_wr));
    check("model_oob", 64'(oob), 64'(m_oob));

    // Asynchronous reset between clock edges, in RUN and again mid-sweep.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst_run");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("sweep_busy", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1 check_reset("rst_sweep");
    @(negedge clk);
    rst = 1'b0;
    wait_init("init_len2");
    access(1'b0, 64'h8, 8'h00, 64'h0, "rd8_reinit");

    // Saturation on the preset instance.
    check("sat_reset", 64'(s_wr_cnt), 64'(SPRE));
    s_req = 1'b1; we = 1'b1; addr = 64'h0; be = 8'hFF; wdata = 64'h55;
    repeat (2) @(negedge clk);
    check("sat_fffe", 64'(s_wr_cnt), 64'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    s_req = 1'b0; we = 1'b0;
    check("sat_ffff", 64'(s_wr_cnt), 64'hFFFF_FFFF);
    check("sat_rdata", s_rdata, 64'h55);
    check("sat_oob", 64'(s_oob), 64'h0);
    check("sat_rdcnt", 64'(s_rd_cnt), 64'(SPRE));
    check("sat_busy", 64'(s_busy), 64'h0);
    check("main_wr_idle", 64'(wr_cnt), 64'(m_wr));
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
